// File: rtl/generic_cntr_bank_if.sv
// ---------------------------------------------------------------------------
// generic_cntr_bank_if - register-ring request/response bundle, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface generic_cntr_bank_if #(
   parameter int SRC_WIDTH  = 2,
   parameter int ADDR_WIDTH = 23
);
   logic                  reg_req;
   logic                  reg_ack;
   logic                  reg_rd_wr_L;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [31:0]           reg_data;
   logic [SRC_WIDTH-1:0]  reg_src;

   modport master (
      output reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
   );

   modport slave (
      input reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
   );
endinterface

`default_nettype wire

// File: rtl/generic_cntr_bank.sv
// ---------------------------------------------------------------------------
// generic_cntr_bank - event counter bank accessed over the register ring, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module generic_cntr_bank #(
   parameter int UDP_REG_SRC_WIDTH  = 2,
   parameter int UDP_REG_ADDR_WIDTH = 23,
   parameter int REG_ADDR_WIDTH     = 5,
   parameter int TAG                = 0,
   parameter int REG_START_ADDR     = 0,
   parameter int NUM_REGS_USED      = 4,
   parameter int REG_WIDTH          = 32,
   parameter int INPUT_WIDTH        = 2,
   parameter int RESET_ON_READ      = 0
)(
   input  logic                                   clk,
   input  logic                                   reset,
   generic_cntr_bank_if.slave                     reg_in,
   generic_cntr_bank_if.master                    reg_out,
   input  logic [NUM_REGS_USED*INPUT_WIDTH-1:0]   updates,
   input  logic [NUM_REGS_USED-1:0]               decrement
);
   localparam int          DW            = INPUT_WIDTH + $clog2(NUM_REGS_USED) + 2;
   localparam int          PW            = (NUM_REGS_USED > 1) ? $clog2(NUM_REGS_USED) : 1;
   localparam int          TW            = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
   localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

   logic                     w_local;
   logic [NUM_REGS_USED-1:0] w_hit;
   logic [31:0]              w_rd_val;
   logic [PW-1:0]            r_ptr;
   logic [REG_WIDTH-1:0]     w_val [NUM_REGS_USED];

   assign w_local = reg_in.reg_req && !reg_in.reg_ack &&
                    (reg_in.reg_addr[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TW'(TAG));

   // Each counter keeps a small signed delta that the round-robin pointer folds
   // into the wide counter, so only one wide adder path per counter is exercised per visit.
   for (genvar i = 0; i < NUM_REGS_USED; i++) begin : g_cntr
      logic [REG_WIDTH-1:0] r_cnt;
      logic signed [DW-1:0] r_dlt;
      logic signed [DW-1:0] w_mag;
      logic signed [DW-1:0] w_upd;
      logic [REG_WIDTH-1:0] w_upd_ext;

      assign w_mag     = DW'(updates[i*INPUT_WIDTH +: INPUT_WIDTH]);
      assign w_upd     = decrement[i] ? -w_mag : w_mag;
      assign w_upd_ext = REG_WIDTH'(w_upd);
      assign w_val[i]  = r_cnt + REG_WIDTH'(r_dlt);
      assign w_hit[i]  = w_local &&
                         (reg_in.reg_addr[REG_ADDR_WIDTH-1:0] == REG_ADDR_WIDTH'(REG_START_ADDR + i));

      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt <= '0;
            r_dlt <= '0;
         end else if (w_hit[i] && !reg_in.reg_rd_wr_L) begin
            r_cnt <= reg_in.reg_data[REG_WIDTH-1:0] + w_upd_ext;
            r_dlt <= '0;
         end else if (w_hit[i] && (RESET_ON_READ != 0)) begin
            r_cnt <= w_upd_ext;
            r_dlt <= '0;
         end else if (r_ptr == PW'(i)) begin
            r_cnt <= w_val[i] + w_upd_ext;
            r_dlt <= '0;
         end else begin
            r_dlt <= r_dlt + w_upd;
         end
      end
   end

   always_comb begin
      w_rd_val = BAD_ADDR_DATA;
      for (int k = 0; k < NUM_REGS_USED; k++) begin
         if (w_hit[k]) w_rd_val = 32'(w_val[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr               <= '0;
         reg_out.reg_req     <= 1'b0;
         reg_out.reg_ack     <= 1'b0;
         reg_out.reg_rd_wr_L <= 1'b0;
         reg_out.reg_addr    <= '0;
         reg_out.reg_data    <= '0;
         reg_out.reg_src     <= '0;
      end else begin
         r_ptr               <= (r_ptr == PW'(NUM_REGS_USED - 1)) ? '0 : r_ptr + PW'(1);
         reg_out.reg_req     <= reg_in.reg_req;
         reg_out.reg_ack     <= reg_in.reg_ack | w_local;
         reg_out.reg_rd_wr_L <= reg_in.reg_rd_wr_L;
         reg_out.reg_addr    <= reg_in.reg_addr;
         reg_out.reg_src     <= reg_in.reg_src;
         reg_out.reg_data    <= (w_local && reg_in.reg_rd_wr_L) ? w_rd_val : reg_in.reg_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_generic_cntr_bank.sv
// ---------------------------------------------------------------------------
// tb_generic_cntr_bank - randomized bench with a value-level counter model, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_generic_cntr_bank;
   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int RAW = 5;
   localparam int UAW = 23;
   localparam int USW = 2;
   localparam int UPW = N * IW;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [UPW-1:0] updates = '0;
   logic [N-1:0]   decrement = '0;

   always #5 clk = ~clk;

   generic_cntr_bank_if #(.SRC_WIDTH(USW), .ADDR_WIDTH(UAW)) rin ();
   generic_cntr_bank_if #(.SRC_WIDTH(USW), .ADDR_WIDTH(UAW)) rout0 ();
   generic_cntr_bank_if #(.SRC_WIDTH(USW), .ADDR_WIDTH(UAW)) rout1 ();

   generic_cntr_bank #(
      .UDP_REG_SRC_WIDTH(USW), .UDP_REG_ADDR_WIDTH(UAW), .REG_ADDR_WIDTH(RAW),
      .TAG(0), .REG_START_ADDR(0), .NUM_REGS_USED(N), .REG_WIDTH(32),
      .INPUT_WIDTH(IW), .RESET_ON_READ(0)
   ) dut0 (
      .clk(clk), .reset(reset), .reg_in(rin), .reg_out(rout0),
      .updates(updates), .decrement(decrement)
   );

   generic_cntr_bank #(
      .UDP_REG_SRC_WIDTH(USW), .UDP_REG_ADDR_WIDTH(UAW), .REG_ADDR_WIDTH(RAW),
      .TAG(0), .REG_START_ADDR(0), .NUM_REGS_USED(N), .REG_WIDTH(32),
      .INPUT_WIDTH(IW), .RESET_ON_READ(1)
   ) dut1 (
      .clk(clk), .reset(reset), .reg_in(rin), .reg_out(rout1),
      .updates(updates), .decrement(decrement)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m0 [N];
   logic [31:0] m1 [N];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic req, input logic ack, input logic rd,
                        input logic [UAW-1:0] addr, input logic [31:0] data,
                        input logic [USW-1:0] src);
      rin.reg_req     = req;
      rin.reg_ack     = ack;
      rin.reg_rd_wr_L = rd;
      rin.reg_addr    = addr;
      rin.reg_data    = data;
      rin.reg_src     = src;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // One clock: predict ring outputs from the counter totals, advance the totals, compare.
   task automatic step();
      logic [31:0] u [N];
      logic        loc;
      logic        hit;
      int          idx;
      logic [27:0] ectl;
      logic [31:0] ed0;
      logic [31:0] ed1;
      if (reset) begin
         ectl = '0;
         ed0  = '0;
         ed1  = '0;
         for (int i = 0; i < N; i++) begin
            m0[i] = '0;
            m1[i] = '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            u[i] = decrement[i] ? -32'(updates[i*IW +: IW]) : 32'(updates[i*IW +: IW]);
         end
         loc  = rin.reg_req && !rin.reg_ack && (rin.reg_addr[UAW-1:RAW] == '0);
         idx  = int'(rin.reg_addr[RAW-1:0]);
         hit  = loc && (idx < N);
         ectl = {rin.reg_req, rin.reg_ack | loc, rin.reg_rd_wr_L, rin.reg_src, rin.reg_addr};
         ed0  = rin.reg_data;
         ed1  = rin.reg_data;
         if (loc && rin.reg_rd_wr_L) begin
            ed0 = hit ? m0[idx] : 32'hDEAD_BEEF;
            ed1 = hit ? m1[idx] : 32'hDEAD_BEEF;
         end
         for (int i = 0; i < N; i++) begin
            if (hit && i == idx && !rin.reg_rd_wr_L) begin
               m0[i] = rin.reg_data + u[i];
               m1[i] = rin.reg_data + u[i];
            end else if (hit && i == idx) begin
               m0[i] = m0[i] + u[i];
               m1[i] = u[i];
            end else begin
               m0[i] = m0[i] + u[i];
               m1[i] = m1[i] + u[i];
            end
         end
      end
      @(posedge clk);
      #1;
      check_val("ctl0", 64'({rout0.reg_req, rout0.reg_ack, rout0.reg_rd_wr_L,
                             rout0.reg_src, rout0.reg_addr}), 64'(ectl));
      check_val("data0", 64'(rout0.reg_data), 64'(ed0));
      check_val("ctl1", 64'({rout1.reg_req, rout1.reg_ack, rout1.reg_rd_wr_L,
                             rout1.reg_src, rout1.reg_addr}), 64'(ectl));
      check_val("data1", 64'(rout1.reg_data), 64'(ed1));
   endtask

   task automatic rd(input int idx);
      drive(1'b1, 1'b0, 1'b1, UAW'(idx), 32'h0, 2'd1);
   endtask

   task automatic wr(input int idx, input logic [31:0] data);
      drive(1'b1, 1'b0, 1'b0, UAW'(idx), data, 2'd2);
   endtask

   initial begin
      logic [UAW-1:0] a;
      idle();
      step();
      step();
      reset = 1'b0;

      // Increment counter 0 by 3 for ten cycles, then read 30.
      updates = UPW'(3);
      repeat (10) step();
      updates = '0;
      rd(0);
      step();
      check_val("rd30", 64'(rout0.reg_data), 64'd30);
      check_val("rd30_ack", 64'(rout0.reg_ack), 64'd1);

      // Wrap upward and downward on counter 1.
      wr(1, 32'hFFFF_FFFE);
      step();
      idle();
      updates = UPW'(3 << 2);
      step();
      updates = '0;
      rd(1);
      step();
      check_val("wrap_up", 64'(rout0.reg_data), 64'h0000_0001);
      wr(1, 32'h0);
      step();
      idle();
      updates   = UPW'(1 << 2);
      decrement = 4'b0010;
      step();
      updates   = '0;
      decrement = '0;
      rd(1);
      step();
      check_val("wrap_dn", 64'(rout0.reg_data), 64'hFFFF_FFFF);

      // Clear-on-read behaviour on counter 2.
      wr(2, 32'h0);
      step();
      idle();
      updates = UPW'(1 << 4);
      repeat (20) step();
      rd(2);
      step();
      check_val("ror_20", 64'(rout1.reg_data), 64'd20);
      rd(2);
      step();
      check_val("ror_1", 64'(rout1.reg_data), 64'd1);
      updates = '0;

      // Back-to-back reads of counter 3 across all pointer phases.
      updates = UPW'(2 << 6);
      for (int k = 0; k < 2 * N; k++) begin
         rd(3);
         step();
      end
      updates = '0;

      // Pass-through cases and an out-of-range index.
      drive(1'b1, 1'b0, 1'b1, UAW'(1 << RAW), 32'h1234_5678, 2'd3);
      step();
      check_val("tag_miss", 64'(rout0.reg_data), 64'h1234_5678);
      drive(1'b1, 1'b1, 1'b1, UAW'(0), 32'h1234_5678, 2'd3);
      step();
      check_val("pre_acked", 64'(rout0.reg_data), 64'h1234_5678);
      rd(4);
      step();
      check_val("oor_data", 64'(rout0.reg_data), 64'hDEAD_BEEF);
      check_val("oor_ack", 64'(rout0.reg_ack), 64'd1);

      // Reset in the middle of a request with live counters.
      updates = 8'b1110_0111;
      idle();
      repeat (3) step();
      rd(0);
      reset = 1'b1;
      step();
      check_val("rst_ack", 64'(rout0.reg_ack), 64'd0);
      reset   = 1'b0;
      updates = '0;
      for (int k = 0; k < N; k++) begin
         rd(k);
         step();
         check_val("rst_zero", 64'(rout0.reg_data), 64'd0);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         updates   = UPW'($urandom);
         decrement = N'($urandom);
         reset     = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 1) == 1) begin
            a = UAW'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a[UAW-1:RAW] = (UAW-RAW)'($urandom_range(1, 3));
            drive(1'b1, $urandom_range(0, 9) == 0, 1'($urandom), a, $urandom, USW'($urandom));
         end else begin
            idle();
         end
         step();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/generic_cntr_bank.md
# generic_cntr_bank

Parametrised bank of NUM_REGS_USED event counters with register-ring access, the full implementation of the counter-register block in the user-data-path register chain. Each counter accumulates a multi-bit increment or decrement every cycle from datapath event inputs. Counters are read and written through the daisy-chained register request ring, optionally clearing on read. The block is inserted in series in the register ring; all ring traffic passes through with one cycle of latency.

## Interface

Parameters:
- UDP_REG_SRC_WIDTH, 2, width of ring source tag
- UDP_REG_ADDR_WIDTH, 23, width of ring address
- REG_ADDR_WIDTH, 5, low address bits decoded inside the block
- TAG, 0, required value of reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]
- REG_START_ADDR, 0, in-block word address of counter 0
- NUM_REGS_USED, 4, number of counters (1..2^REG_ADDR_WIDTH - REG_START_ADDR)
- REG_WIDTH, 32, counter width (≤ 32)
- INPUT_WIDTH, 2, per-counter update magnitude width
- RESET_ON_READ, 0, 1 = a ring read clears the counter

Ports:
- clk, in, 1, sole clock
- reset, in, 1, synchronous, active-high
- reg_req_in / reg_ack_in / reg_rd_wr_L_in, in, 1 each, ring request, prior ack, read(1)/write(0)
- reg_addr_in, in, UDP_REG_ADDR_WIDTH, ring address
- reg_data_in, in, 32, ring write data / upstream read data
- reg_src_in, in, UDP_REG_SRC_WIDTH, ring source
- reg_req_out / reg_ack_out / reg_rd_wr_L_out, out, 1 each, registered ring outputs
- reg_addr_out, out, UDP_REG_ADDR_WIDTH; reg_data_out, out, 32; reg_src_out, out, UDP_REG_SRC_WIDTH
- updates, in, NUM_REGS_USED*INPUT_WIDTH, slice i = magnitude for counter i this cycle
- decrement, in, NUM_REGS_USED, bit i = 1 subtracts slice i, 0 adds it

## Operation

- Storage: main counter cnt[i] (REG_WIDTH) plus signed pending delta dlt[i], width DW = INPUT_WIDTH + clog2(NUM_REGS_USED) + 2. Counter value V(i) = cnt[i] + sign-extended dlt[i], modulo 2^REG_WIDTH.
- Every cycle, each counter's update u(i) = ±updates slice (−slice when decrement[i] = 1) is added to dlt[i].
- Fold: a round-robin pointer p (0..NUM_REGS_USED-1, wraps) visits one counter per cycle: cnt[p] ← cnt[p] + dlt[p] + u(p), dlt[p] ← 0. The pointer advances every cycle, including during ring accesses. Every dlt is folded within NUM_REGS_USED cycles, so dlt never overflows.
- Arithmetic wraps modulo 2^REG_WIDTH in both directions. No saturation.
- Ring decode: a request is local when reg_req_in = 1, reg_ack_in = 0, and the tag matches. idx = reg_addr_in[REG_ADDR_WIDTH-1:0] − REG_START_ADDR.
- Local, idx in range, read: reg_data_out = V(idx) as of the request cycle, excluding that cycle's u(idx), zero-extended to 32 bits. reg_ack_out = 1. If RESET_ON_READ: cnt[idx] ← u(idx), dlt[idx] ← 0.
- Local, idx in range, write: cnt[idx] ← reg_data_in[REG_WIDTH-1:0] + u(idx), dlt[idx] ← 0. reg_data_out = reg_data_in. reg_ack_out = 1.
- The ring access to idx overrides the fold when p = idx. Events arriving in the access cycle are never lost.
- Local, idx out of range: reg_ack_out = 1. A read returns 32'hDEAD_BEEF. A write has no effect.
- Non-local, or already acked: all ring fields are forwarded unchanged.

## Timing

- Ring latency is exactly 1 cycle. All outputs are registered. reg_req_out, reg_rd_wr_L_out, reg_addr_out and reg_src_out are always reg_*_in delayed by one cycle.
- Back-to-back requests on consecutive cycles are supported. A read in cycle t+1 of a counter written in cycle t returns the written value plus u in cycle t.
- Reset: all cnt, dlt, p ← 0. All ring outputs are 0 in the cycle after reset is sampled high. Updates and requests during reset are discarded. Reset during a pending ring request drops it, with no ack.
- A counter's events are visible to a read issued one cycle later.

## Test plan

- Reset, then NUM_REGS_USED=4: drive updates slice 0 = 3 (inc) for 10 cycles, then read counter 0 → data 30, ack 1 on next cycle.
- Write counter 1 = 32'hFFFF_FFFE, then increment by 3 for one cycle, then read → 32'h0000_0001 (wrap). Write 0, decrement by 1, read → 32'hFFFF_FFFF.
- RESET_ON_READ=1: increment counter 2 by 1 every cycle. Read at a cycle where prior total = 20 → returns 20. An immediate second read returns 1.
- Read counter 3 exactly when p = 3 while slice 3 = 2: returns the pre-cycle value, and the next read returns that value + 2 with no loss. Repeat for every p phase.
- Tag mismatch, and request with reg_ack_in = 1, data 32'h1234_5678: forwarded unchanged, 1-cycle delay, counters untouched. Tag match with idx = 4: ack 1, data 32'hDEAD_BEEF.
- Assert reset mid-request with counters nonzero: outputs 0 next cycle, all reads afterward return 0.
